gcd_lcm_mmio: RTL and testbench

GCD_LCM_MMIO -- requirements
Module: gcd_lcm_mmio

---
 rtl/gcd_lcm_mmio.sv | 144 ++++++++++++++
 tb/tb_gcd_lcm_mmio.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/gcd_lcm_mmio.sv
// Memory-mapped GCD/LCM accelerator: operand/control/status/result registers on a CPU data bus,
// with a subtract-based GCD engine and an add-based LCM engine sharing two working registers.
module gcd_lcm_mmio #(
    parameter logic [31:0] BASE = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Busy,
    output logic        Done
);

    localparam int unsigned DW = 32;
    localparam int unsigned OW = 16;

    localparam logic [DW-1:0] OFF_OPA    = 32'h0000_0000;
    localparam logic [DW-1:0] OFF_OPB    = 32'h0000_0004;
    localparam logic [DW-1:0] OFF_CTRL   = 32'h0000_0008;
    localparam logic [DW-1:0] OFF_STATUS = 32'h0000_000C;
    localparam logic [DW-1:0] OFF_RESULT = 32'h0000_0010;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN_GCD = 2'd1,
        RUN_LCM = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [OW-1:0] opa_q, opa_d;
    logic [OW-1:0] opb_q, opb_d;
    logic [DW-1:0] x_q, x_d;
    logic [DW-1:0] y_q, y_d;
    logic [DW-1:0] result_q, result_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic [DW-1:0] off_c;
    logic          wr_opa_c, wr_opb_c, wr_ctrl_c;
    logic          unused_wdata;

    // BASE is word aligned, so any misaligned address misses every exact offset match.
    assign off_c     = DataAdr - BASE;
    assign wr_opa_c  = MemWrite && (off_c == OFF_OPA);
    assign wr_opb_c  = MemWrite && (off_c == OFF_OPB);
    assign wr_ctrl_c = MemWrite && (off_c == OFF_CTRL);

    assign unused_wdata = ^WriteData[DW-1:OW];

    // Load path, combinational from the address.
    always_comb begin
        ReadData = '0;
        case (off_c)
            OFF_OPA:    ReadData = DW'(opa_q);
            OFF_OPB:    ReadData = DW'(opb_q);
            OFF_STATUS: ReadData = {30'd0, done_q, busy_q};
            OFF_RESULT: ReadData = result_q;
            default:    ReadData = '0;
        endcase
    end

    // Next-state and datapath update.
    always_comb begin
        state_d  = state_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        x_d      = x_q;
        y_d      = y_q;
        result_d = result_q;
        busy_d   = busy_q;
        done_d   = done_q;

        case (state_q)
            IDLE: begin
                if (wr_opa_c) opa_d = WriteData[OW-1:0];
                if (wr_opb_c) opb_d = WriteData[OW-1:0];
                if (wr_ctrl_c && WriteData[0]) begin
                    x_d     = DW'(opa_q);
                    y_d     = DW'(opb_q);
                    done_d  = 1'b0;
                    busy_d  = 1'b1;
                    state_d = WriteData[1] ? RUN_LCM : RUN_GCD;
                end
            end
            RUN_GCD: begin
                // Zero can only be present on the first cycle; x|y picks the nonzero operand.
                if ((x_q == '0) || (y_q == '0) || (x_q == y_q)) begin
                    result_d = x_q | y_q;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = IDLE;
                end else if (x_q > y_q) begin
                    x_d = x_q - y_q;
                end else begin
                    y_d = y_q - x_q;
                end
            end
            RUN_LCM: begin
                if ((x_q == '0) || (y_q == '0) || (x_q == y_q)) begin
                    result_d = ((x_q == '0) || (y_q == '0)) ? '0 : x_q;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = IDLE;
                end else if (x_q < y_q) begin
                    x_d = x_q + DW'(opa_q);
                end else begin
                    y_d = y_q + DW'(opb_q);
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            opa_q    <= '0;
            opb_q    <= '0;
            x_q      <= '0;
            y_q      <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            x_q      <= x_d;
            y_q      <= y_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign Busy = busy_q;
    assign Done = done_q;

endmodule

// File: tb/tb_gcd_lcm_mmio.sv
// Directed bench for gcd_lcm_mmio: register access, GCD/LCM results and latency,
// zero operands, busy-time store filtering, mid-run reset and address decode.
module tb_gcd_lcm_mmio;

    localparam logic [31:0] BASE = 32'h0000_0100;
    localparam logic [31:0] A_OPA    = BASE + 32'h00;
    localparam logic [31:0] A_OPB    = BASE + 32'h04;
    localparam logic [31:0] A_CTRL   = BASE + 32'h08;
    localparam logic [31:0] A_STATUS = BASE + 32'h0C;
    localparam logic [31:0] A_RESULT = BASE + 32'h10;

    logic        clk;
    logic        reset;
    logic        MemWrite;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        Busy;
    logic        Done;

    int n_cmp;
    int n_err;

    gcd_lcm_mmio #(.BASE(BASE)) dut (
        .clk       (clk),
        .reset     (reset),
        .MemWrite  (MemWrite),
        .DataAdr   (DataAdr),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .Busy      (Busy),
        .Done      (Done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One store; returns 1ns after the edge that captures it.
    task automatic store(input logic [31:0] adr, input logic [31:0] data);
        @(negedge clk);
        MemWrite  = 1'b1;
        DataAdr   = adr;
        WriteData = data;
        @(posedge clk);
        #1;
        MemWrite  = 1'b0;
        DataAdr   = 32'h0;
        WriteData = 32'h0;
    endtask

    task automatic load_chk(input string tag, input logic [31:0] adr, input logic [31:0] exp);
        @(negedge clk);
        DataAdr = adr;
        #1;
        chk(tag, ReadData, exp);
        DataAdr = 32'h0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int waited;
        n_cmp     = 0;
        n_err     = 0;
        reset     = 1'b0;
        MemWrite  = 1'b0;
        DataAdr   = 32'h0;
        WriteData = 32'h0;

        // Reset state
        #12;
        chk("rst_busy", {31'd0, Busy}, 32'd0);
        chk("rst_done", {31'd0, Done}, 32'd0);
        load_chk("rst_result", A_RESULT, 32'd0);
        load_chk("rst_opa", A_OPA, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // GCD(105,42): upper store bits dropped, 3 steps, done at start+4
        store(A_OPA, 32'hABCD_0069);
        store(A_OPB, 32'd42);
        load_chk("opa_rb", A_OPA, 32'd105);
        load_chk("opb_rb", A_OPB, 32'd42);
        store(A_CTRL, 32'd1);
        chk("gcd1_busy0", {31'd0, Busy}, 32'd1);
        chk("gcd1_done0", {31'd0, Done}, 32'd0);
        cycles(3);
        chk("gcd1_busy3", {31'd0, Busy}, 32'd1);
        chk("gcd1_done3", {31'd0, Done}, 32'd0);
        cycles(1);
        chk("gcd1_done4", {31'd0, Done}, 32'd1);
        chk("gcd1_busy4", {31'd0, Busy}, 32'd0);
        load_chk("gcd1_result", A_RESULT, 32'd21);
        load_chk("gcd1_status", A_STATUS, 32'd2);

        // LCM(3,7): 8 steps, done at start+9
        store(A_OPA, 32'd3);
        store(A_OPB, 32'd7);
        store(A_CTRL, 32'd3);
        chk("lcm1_done0", {31'd0, Done}, 32'd0);
        cycles(8);
        chk("lcm1_done8", {31'd0, Done}, 32'd0);
        cycles(1);
        chk("lcm1_done9", {31'd0, Done}, 32'd1);
        load_chk("lcm1_result", A_RESULT, 32'd21);

        // Zero operands finish on the first run cycle
        store(A_OPA, 32'd0);
        store(A_OPB, 32'd35);
        store(A_CTRL, 32'd1);
        chk("gcd0_done0", {31'd0, Done}, 32'd0);
        cycles(1);
        chk("gcd0_done1", {31'd0, Done}, 32'd1);
        load_chk("gcd0_result", A_RESULT, 32'd35);
        store(A_CTRL, 32'd3);
        chk("lcm0_done0", {31'd0, Done}, 32'd0);
        cycles(1);
        chk("lcm0_done1", {31'd0, Done}, 32'd1);
        load_chk("lcm0_result", A_RESULT, 32'd0);
        store(A_OPB, 32'd0);
        store(A_CTRL, 32'd1);
        chk("gcd00_done0", {31'd0, Done}, 32'd0);
        cycles(1);
        chk("gcd00_done1", {31'd0, Done}, 32'd1);
        load_chk("gcd00_result", A_RESULT, 32'd0);

        // GCD(65535,1): stores to OPA and CTRL while busy are dropped
        store(A_OPA, 32'h0000_FFFF);
        store(A_OPB, 32'd1);
        store(A_CTRL, 32'd1);
        store(A_OPA, 32'd5);
        store(A_CTRL, 32'd3);
        load_chk("busy_opa", A_OPA, 32'h0000_FFFF);
        load_chk("busy_status", A_STATUS, 32'd1);
        waited = 0;
        while (!Done && waited < 70000) begin
            cycles(1);
            waited++;
        end
        chk("long_done", {31'd0, Done}, 32'd1);
        load_chk("long_result", A_RESULT, 32'd1);
        load_chk("long_opa", A_OPA, 32'h0000_FFFF);
        load_chk("long_status", A_STATUS, 32'd2);

        // Reset mid-LCM aborts; a new GCD runs normally afterwards
        store(A_OPA, 32'd3);
        store(A_OPB, 32'd7);
        store(A_CTRL, 32'd3);
        cycles(3);
        reset = 1'b0;
        #1;
        chk("abort_busy", {31'd0, Busy}, 32'd0);
        chk("abort_done", {31'd0, Done}, 32'd0);
        DataAdr = A_RESULT;
        #1;
        chk("abort_result", ReadData, 32'd0);
        DataAdr = 32'h0;
        @(negedge clk);
        reset = 1'b1;
        store(A_OPA, 32'd21);
        store(A_OPB, 32'd21);
        store(A_CTRL, 32'd1);
        cycles(1);
        chk("post_done1", {31'd0, Done}, 32'd1);
        load_chk("post_result", A_RESULT, 32'd21);

        // Decode: unmapped, read-only, misaligned and start-less CTRL stores are inert
        store(BASE + 32'h14, 32'hDEAD_BEEF);
        store(A_RESULT, 32'hDEAD_BEEF);
        store(A_STATUS, 32'h0000_0001);
        store(BASE + 32'h01, 32'd99);
        store(A_CTRL, 32'd2);
        load_chk("ro_result", A_RESULT, 32'd21);
        load_chk("ro_status", A_STATUS, 32'd2);
        load_chk("mis_opa", A_OPA, 32'd21);
        load_chk("out_low", 32'h0000_0000, 32'd0);
        load_chk("out_hi", BASE + 32'h14, 32'd0);
        load_chk("ctrl_read", A_CTRL, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
